aoc5_sort_scheduler: RTL and testbench

//  Top-level sequencer for the AoC5 ping/pong external sort. On start it runs one
//  16-element bitonic run-forming pass (sort_phase), then log2 merge passes, doubling run length each pass.

---
 rtl/aoc5_sort_scheduler.sv | 156 +++++++++++++++
 tb/tb_aoc5_sort_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/aoc5_sort_scheduler.sv
// Sequencer for the AoC5 ping/pong external sort: one run-forming sort pass, then
// merge passes with doubling run length, bank swapping and a per-phase watchdog.
module aoc5_sort_scheduler #(
    parameter int unsigned BASE_RUN       = 16,
    parameter int unsigned MAX_PASSES     = 24,
    parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start_in,
    input  logic [31:0]                         stream_len_in,
    input  logic                                sort_done_in,
    input  logic                                merge_done_in,
    output logic                                phase_rst_out,
    output logic                                sort_en_out,
    output logic                                merge_en_out,
    output logic [31:0]                         run_len_out,
    output logic                                src_bank_b_out,
    output logic                                parity_clock_out,
    output logic [$clog2(MAX_PASSES+1)-1:0]     pass_cnt_out,
    output logic                                busy_out,
    output logic                                done_out,
    output logic                                result_bank_b_out,
    output logic                                error_out
);
    localparam int unsigned PW = $clog2(MAX_PASSES + 1);
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, SORT_INIT, SORT_RUN, MERGE_INIT, MERGE_RUN, DONE, ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     len_q, len_d;
    logic [31:0]     run_q, run_d, run_next;
    logic [PW-1:0]   pass_q, pass_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic            src_q, src_d;
    logic            res_q, res_d;
    logic            err_q, err_d;
    logic            parity_q;
    logic            busy;

    assign busy = (state_q == SORT_INIT) || (state_q == SORT_RUN) ||
                  (state_q == MERGE_INIT) || (state_q == MERGE_RUN);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            run_q    <= 32'(BASE_RUN);
            pass_q   <= '0;
            wd_q     <= '0;
            src_q    <= 1'b0;
            res_q    <= 1'b0;
            err_q    <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            run_q    <= run_d;
            pass_q   <= pass_d;
            wd_q     <= wd_d;
            src_q    <= src_d;
            res_q    <= res_d;
            err_q    <= err_d;
            parity_q <= busy ? ~parity_q : 1'b0;
        end
    end

    // Run length saturates at 2^31 so oversized streams end in the pass-limit error.
    assign run_next = run_q[31] ? run_q : {run_q[30:0], 1'b0};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        run_d   = run_q;
        pass_d  = pass_q;
        wd_d    = wd_q;
        src_d   = src_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start_in) begin
                    len_d   = stream_len_in;
                    run_d   = 32'(BASE_RUN);
                    pass_d  = '0;
                    src_d   = 1'b0;
                    res_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = (stream_len_in == '0) ? DONE : SORT_INIT;
                end
            end
            SORT_INIT: begin
                wd_d    = '0;
                state_d = SORT_RUN;
            end
            SORT_RUN: begin
                if (sort_done_in) begin
                    if (len_q <= 32'(BASE_RUN)) begin
                        res_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        src_d   = 1'b1;
                        state_d = MERGE_INIT;
                    end
                end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            MERGE_INIT: begin
                wd_d    = '0;
                state_d = MERGE_RUN;
            end
            MERGE_RUN: begin
                if (merge_done_in) begin
                    pass_d = pass_q + PW'(1);
                    run_d  = run_next;
                    src_d  = ~src_q;
                    if (run_next >= len_q) begin
                        res_d   = ~src_q;
                        state_d = DONE;
                    end else if (pass_q + PW'(1) == PW'(MAX_PASSES)) begin
                        err_d   = 1'b1;
                        state_d = ERROR;
                    end else begin
                        state_d = MERGE_INIT;
                    end
                end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign phase_rst_out     = (state_q == SORT_INIT) || (state_q == MERGE_INIT);
    assign sort_en_out       = (state_q == SORT_RUN);
    assign merge_en_out      = (state_q == MERGE_RUN);
    assign run_len_out       = run_q;
    assign src_bank_b_out    = src_q;
    assign parity_clock_out  = parity_q & busy;
    assign pass_cnt_out      = pass_q;
    assign busy_out          = busy;
    assign done_out          = (state_q == DONE);
    assign result_bank_b_out = res_q;
    assign error_out         = err_q;

endmodule

// File: tb/tb_aoc5_sort_scheduler.sv
// Scoreboard bench for aoc5_sort_scheduler: directed runs push expected completion
// records; a monitor checks them when done_out or error_out rises.
module tb_aoc5_sort_scheduler;
    logic        clock, reset, start_in, sort_done_in, merge_done_in;
    logic [31:0] stream_len_in;
    logic        phase_rst_out, sort_en_out, merge_en_out, src_bank_b_out;
    logic        parity_clock_out, busy_out, done_out, result_bank_b_out, error_out;
    logic [31:0] run_len_out;
    logic [4:0]  pass_cnt_out;

    typedef struct {
        logic        done;
        logic        err;
        logic        res_b;
        logic [4:0]  pass;
        logic [31:0] run_len;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   rst_pulses = 0, sort_cycles = 0, merge_cycles = 0;
    logic prev_done = 1'b0, prev_err = 1'b0;

    aoc5_sort_scheduler #(.TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset), .start_in(start_in), .stream_len_in(stream_len_in),
        .sort_done_in(sort_done_in), .merge_done_in(merge_done_in),
        .phase_rst_out(phase_rst_out), .sort_en_out(sort_en_out), .merge_en_out(merge_en_out),
        .run_len_out(run_len_out), .src_bank_b_out(src_bank_b_out),
        .parity_clock_out(parity_clock_out), .pass_cnt_out(pass_cnt_out),
        .busy_out(busy_out), .done_out(done_out), .result_bank_b_out(result_bank_b_out),
        .error_out(error_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: completion records are compared when done or error rises.
    always @(negedge clock) begin
        if (phase_rst_out) rst_pulses++;
        if (sort_en_out)   sort_cycles++;
        if (merge_en_out)  merge_cycles++;
        if ((done_out && !prev_done) || (error_out && !prev_err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_completion", 64'(done_out), 64'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_done",    64'(done_out),          64'(e.done));
                chk("sb_error",   64'(error_out),         64'(e.err));
                chk("sb_result",  64'(result_bank_b_out), 64'(e.res_b));
                chk("sb_pass",    64'(pass_cnt_out),      64'(e.pass));
                chk("sb_run_len", 64'(run_len_out),       64'(e.run_len));
            end
        end
        prev_done = done_out;
        prev_err  = error_out;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_en(input bit merge, input string name);
        int n = 0;
        while (!(merge ? merge_en_out : sort_en_out) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk({name, "_timeout"}, 64'(0), 64'(1));
    endtask

    task automatic pulse_done(input bit merge);
        if (merge) merge_done_in = 1'b1; else sort_done_in = 1'b1;
        tick();
        merge_done_in = 1'b0;
        sort_done_in  = 1'b0;
    endtask

    task automatic start(input logic [31:0] len);
        stream_len_in = len;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    task automatic zero_counters();
        rst_pulses = 0;
        sort_cycles = 0;
        merge_cycles = 0;
    endtask

    function automatic logic [8:0] flags();
        return {busy_out, done_out, sort_en_out, merge_en_out, phase_rst_out,
                src_bank_b_out, parity_clock_out, error_out, result_bank_b_out};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start_in = 1'b0; sort_done_in = 1'b0; merge_done_in = 1'b0;
        stream_len_in = '0;
        tick(); tick();
        reset = 1'b0;
        chk("reset_flags",   64'(flags()),      64'(0));
        chk("reset_run_len", 64'(run_len_out),  64'd16);
        chk("reset_pass",    64'(pass_cnt_out), 64'd0);

        // len=10: single sort phase, result in bank B
        zero_counters();
        exp_q.push_back('{done: 1'b1, err: 1'b0, res_b: 1'b1, pass: 5'd0, run_len: 32'd16});
        start(32'd10);
        chk("len10_init_flags", 64'(flags()), 64'b100010000);
        tick();
        chk("len10_run_flags",  64'(flags()), 64'b101000100);
        tick();
        pulse_done(1'b0);
        chk("len10_done", 64'(done_out), 64'd1);
        tick(); tick();
        chk("len10_merge_cycles", 64'(merge_cycles), 64'd0);
        chk("len10_rst_pulses",   64'(rst_pulses),   64'd1);

        // len=100: three merge passes writing A, B, A
        zero_counters();
        exp_q.push_back('{done: 1'b1, err: 1'b0, res_b: 1'b0, pass: 5'd3, run_len: 32'd128});
        start(32'd100);
        wait_en(1'b0, "len100_sort");
        pulse_done(1'b0);
        for (int p = 0; p < 3; p++) begin
            wait_en(1'b1, "len100_merge");
            chk("len100_run_len", 64'(run_len_out),    64'(32'd16 << p));
            chk("len100_src",     64'(src_bank_b_out), 64'((p % 2) == 0));
            pulse_done(1'b1);
        end
        tick(); tick();
        chk("len100_rst_pulses", 64'(rst_pulses), 64'd4);

        // len=0 from IDLE: straight to DONE
        reset = 1'b1; tick(); reset = 1'b0; tick();
        zero_counters();
        exp_q.push_back('{done: 1'b1, err: 1'b0, res_b: 1'b0, pass: 5'd0, run_len: 32'd16});
        start(32'd0);
        chk("len0_done", 64'(done_out), 64'd1);
        chk("len0_busy", 64'(busy_out), 64'd0);
        tick(); tick();
        chk("len0_activity", 64'(rst_pulses + sort_cycles + merge_cycles), 64'd0);

        // watchdog: sort_done never arrives
        zero_counters();
        exp_q.push_back('{done: 1'b0, err: 1'b1, res_b: 1'b0, pass: 5'd0, run_len: 32'd16});
        start(32'd50);
        repeat (8) tick();
        chk("wd_not_yet", 64'(error_out), 64'd0);
        tick();
        chk("wd_error",       64'(error_out),   64'd1);
        chk("wd_busy",        64'(busy_out),    64'd0);
        chk("wd_sort_en",     64'(sort_en_out), 64'd0);
        chk("wd_sort_cycles", 64'(sort_cycles), 64'd8);
        exp_q.push_back('{done: 1'b1, err: 1'b0, res_b: 1'b1, pass: 5'd0, run_len: 32'd16});
        start(32'd10);
        chk("wd_restart_err", 64'(error_out),     64'd0);
        chk("wd_restart_rst", 64'(phase_rst_out), 64'd1);
        tick();
        pulse_done(1'b0);
        tick();

        // start ignored in MERGE_RUN, then reset mid-merge
        start(32'd100);
        wait_en(1'b0, "midrst_sort");
        pulse_done(1'b0);
        wait_en(1'b1, "midrst_merge");
        start(32'd5);
        chk("busy_start_merge_en", 64'(merge_en_out),  64'd1);
        chk("busy_start_rst",      64'(phase_rst_out), 64'd0);
        chk("busy_start_run_len",  64'(run_len_out),   64'd16);
        reset = 1'b1;
        tick();
        chk("midrst_flags",   64'(flags()),      64'(0));
        chk("midrst_run_len", 64'(run_len_out),  64'd16);
        chk("midrst_pass",    64'(pass_cnt_out), 64'd0);
        reset = 1'b0;
        tick();

        // merge_done held high across MERGE_INIT: one pass per MERGE_RUN entry
        exp_q.push_back('{done: 1'b1, err: 1'b0, res_b: 1'b1, pass: 5'd2, run_len: 32'd64});
        start(32'd40);
        wait_en(1'b0, "hold_sort");
        pulse_done(1'b0);
        merge_done_in = 1'b1;
        chk("hold_init1_rst", 64'(phase_rst_out), 64'd1);
        tick();
        chk("hold_run1_pass", 64'(pass_cnt_out), 64'd0);
        tick();
        chk("hold_init2_pass", 64'(pass_cnt_out), 64'd1);
        tick();
        chk("hold_run2_pass", 64'(pass_cnt_out), 64'd1);
        tick();
        chk("hold_done_pass", 64'(pass_cnt_out), 64'd2);
        merge_done_in = 1'b0;
        tick(); tick();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
